// File: rtl/sample_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sample_fifo_ctrl
//
// Synchronous FIFO controller for the input-sample path. Samples from a
// valid/ready slave stream are written into an external simple-dual-port RAM.
// RAM port A is write-only. RAM port B is read-only and has a registered
// output stage, so a read takes 2 cycles. Words are prefetched through a
// 2-stage in-flight pipeline (v1, v2) into a 3-entry output buffer. This lets
// the master stream sustain one sample per cycle.
//
// Ports
//   clk_i              single clock for the block and the RAM
//   rst_i              synchronous, active-high reset
//   s_data_i/_valid_i  input sample stream
//   s_ready_o          block can accept a sample (RAM not full)
//   m_data_o/_valid_o  output sample stream (head of output buffer)
//   m_ready_i          downstream accepts the head sample
//   count_o            samples held: RAM + in flight + output buffer
//   empty_o            count_o == 0
//   overflow_o         sticky: a sample was offered while s_ready_o was low
//   mem_wr_*           RAM port A (write) controls
//   mem_rd_en_o        RAM port B clock enable (read issue)
//   mem_rdout_clken_o  RAM port B output-register clock enable
//   mem_rd_addr_o      RAM port B address
//   mem_rd_data_i      RAM port B registered read data
// ---------------------------------------------------------------------------
module sample_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [ADDR_WIDTH+1:0]   count_o,
  output logic                    empty_o,
  output logic                    overflow_o,
  output logic                    mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
  output logic                    mem_rd_en_o,
  output logic                    mem_rdout_clken_o,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data_i
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam int CNT_WIDTH = ADDR_WIDTH + 2;
  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(ADDR_DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic                  r_v1;
  logic                  r_v2;
  logic [1:0]            r_ob_count;
  logic [DATA_WIDTH-1:0] r_ob_data [3];
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_count;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0]  w_mem_count;
  logic [PTR_WIDTH-1:0]  w_mem_count_nxt;
  logic                  w_full;
  logic                  w_s_ready;
  logic                  w_accept;
  logic                  w_m_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic [1:0]            w_wr_idx;
  logic [1:0]            w_ob_count_nxt;
  logic [DATA_WIDTH-1:0] w_ob_data_nxt [3];
  logic [CNT_WIDTH-1:0]  w_count_nxt;

  // Words written but not yet issued for read. The extra pointer bit
  // separates "full" (difference == depth) from "empty" (difference == 0).
  assign w_mem_count = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_mem_count == DEPTH_P);
  assign w_s_ready   = !rst_i && !w_full;
  assign w_accept    = s_valid_i && w_s_ready;

  assign w_m_valid   = !rst_i && (r_ob_count != 2'd0);
  assign w_pop       = w_m_valid && m_ready_i;
  // The RAM output register holds the word issued two cycles ago while v2 is set.
  assign w_push      = r_v2;

  // Buffer slots already committed: occupied entries plus reads in flight.
  // A read is issued only if its word is guaranteed a free slot on arrival.
  // The comparison is written as occ < 3 + pop to avoid an underflow.
  assign w_occ   = {1'b0, r_ob_count} + {2'b00, r_v1} + {2'b00, r_v2};
  assign w_issue = !rst_i && (w_mem_count != {PTR_WIDTH{1'b0}}) &&
                   (w_occ < (3'd3 + {2'b00, w_pop}));

  // Output-buffer next state: shift on pop, then append the arriving word
  // behind the surviving entries so order is kept on simultaneous push/pop.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ob_data_nxt[i] = r_ob_data[i];
    end
    if (w_pop) begin
      w_ob_data_nxt[0] = r_ob_data[1];
      w_ob_data_nxt[1] = r_ob_data[2];
      w_ob_data_nxt[2] = {DATA_WIDTH{1'b0}};
      w_wr_idx         = r_ob_count - 2'd1;
    end else begin
      w_wr_idx         = r_ob_count;
    end
    if (w_push) begin
      case (w_wr_idx)
        2'd0:    w_ob_data_nxt[0] = mem_rd_data_i;
        2'd1:    w_ob_data_nxt[1] = mem_rd_data_i;
        2'd2:    w_ob_data_nxt[2] = mem_rd_data_i;
        // Index 3 cannot occur because issue control never over-commits the buffer.
        default: w_ob_data_nxt[2] = r_ob_data[2];
      endcase
    end else begin
      w_ob_data_nxt[0] = w_ob_data_nxt[0];
    end
  end

  assign w_ob_count_nxt  = r_ob_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_mem_count_nxt = w_mem_count + {{(PTR_WIDTH-1){1'b0}}, w_accept}
                                       - {{(PTR_WIDTH-1){1'b0}}, w_issue};
  // Count as it will stand after this edge, so count_o tracks the registered state.
  assign w_count_nxt = CNT_WIDTH'(w_mem_count_nxt) + CNT_WIDTH'(w_issue) +
                       CNT_WIDTH'(r_v1) + CNT_WIDTH'(w_ob_count_nxt);

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // Pointers, read pipeline, output buffer, count and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= {PTR_WIDTH{1'b0}};
      r_rd_ptr   <= {PTR_WIDTH{1'b0}};
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_ob_count <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_ob_data[i] <= {DATA_WIDTH{1'b0}};
      end
      r_overflow <= 1'b0;
      r_count    <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_v1       <= w_issue;
      r_v2       <= r_v1;
      r_ob_count <= w_ob_count_nxt;
      for (int i = 0; i < 3; i++) begin
        r_ob_data[i] <= w_ob_data_nxt[i];
      end
      if (s_valid_i && !w_s_ready) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      r_count    <= w_count_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Handshake and RAM strobes are masked while reset is held, so nothing
  // moves during the reset cycle even though the state clears only at the edge.
  assign s_ready_o         = w_s_ready;
  assign m_valid_o         = w_m_valid;
  assign m_data_o          = r_ob_data[0];
  assign count_o           = rst_i ? {CNT_WIDTH{1'b0}} : r_count;
  assign empty_o           = (count_o == {CNT_WIDTH{1'b0}});
  assign overflow_o        = r_overflow;

  assign mem_wr_en_o       = w_accept;
  assign mem_wr_addr_o     = r_wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wr_data_o     = s_data_i;
  assign mem_rd_en_o       = w_issue;
  assign mem_rdout_clken_o = !rst_i && r_v1;
  assign mem_rd_addr_o     = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
module tb_sample_fifo_ctrl;

  localparam int DW = 32;
  localparam int AD = 1024;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [AW+1:0] count_o;
  logic          empty_o;
  logic          overflow_o;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_wr_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic          mem_rd_en_o;
  logic          mem_rdout_clken_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [DW-1:0] mem_rd_data_i;

  sample_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_rdout_clken_o(mem_rdout_clken_o),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Simple-dual-port RAM with registered output (2-cycle read)
  logic [DW-1:0] ram [AD];
  logic [DW-1:0] ram_q1 = '0;
  logic [DW-1:0] ram_q2 = '0;
  always @(posedge clk_i) begin
    if (mem_wr_en_o) ram[mem_wr_addr_o] <= mem_wr_data_o;
    if (mem_rd_en_o) ram_q1 <= ram[mem_rd_addr_o];
    if (mem_rdout_clken_o) ram_q2 <= ram_q1;
  end
  assign mem_rd_data_i = ram_q2;

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int occ_max = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Monitor: evaluates the transfer that happens at the coming posedge
  always @(negedge clk_i) begin
    int occ;
    #2;
    occ = int'(dut.r_ob_count) + int'(dut.r_v1) + int'(dut.r_v2);
    if (occ > occ_max) occ_max = occ;
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {32'd0, m_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("out_data", {32'd0, m_data_o}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // One cycle of stimulus: called at a negedge, returns at the next negedge
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = r;
    #1;
    if (v && s_ready_o) exp_q.push_back(d);
    @(negedge clk_i);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty_o) && n < 3000) begin
      drive(1'b0, '0, 1'b1);
      n++;
    end
    chk(name, {63'd0, (n < 3000)}, 64'd1);
  endtask

  initial begin
    int acc;
    int gaps;
    int rdy_drop;
    #4_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int gaps;
    int rdy_drop;
    // ---- 1: reset and single word ----
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_s_ready", {63'd0, s_ready_o}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_count", {52'd0, count_o}, 64'd0);
    chk("rst_empty", {63'd0, empty_o}, 64'd1);
    chk("rst_wr_en", {63'd0, mem_wr_en_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, s_ready_o}, 64'd1);
    chk("post_rst_ovf", {63'd0, overflow_o}, 64'd0);
    @(negedge clk_i);
    drive(1'b1, 32'hA5A5_0001, 1'b1);               // accepted at edge N
    chk("t1_cnt_n0", {52'd0, count_o}, 64'd1);
    chk("t1_val_n0", {63'd0, m_valid_o}, 64'd0);
    drive(1'b0, '0, 1'b1);
    chk("t1_cnt_n1", {52'd0, count_o}, 64'd1);
    chk("t1_val_n1", {63'd0, m_valid_o}, 64'd0);
    drive(1'b0, '0, 1'b1);
    chk("t1_cnt_n2", {52'd0, count_o}, 64'd1);
    chk("t1_val_n2", {63'd0, m_valid_o}, 64'd0);
    drive(1'b0, '0, 1'b1);
    chk("t1_cnt_n3", {52'd0, count_o}, 64'd1);
    chk("t1_val_n3", {63'd0, m_valid_o}, 64'd1);
    chk("t1_data_n3", {32'd0, m_data_o}, {32'd0, 32'hA5A5_0001});
    drive(1'b0, '0, 1'b1);
    chk("t1_cnt_n4", {52'd0, count_o}, 64'd0);
    chk("t1_empty_n4", {63'd0, empty_o}, 64'd1);

    // ---- 2: streaming 0..4095 ----
    gaps = 0;
    rdy_drop = 0;
    for (int i = 0; i < 4096; i++) begin
      if (!s_ready_o) rdy_drop++;
      drive(1'b1, DW'(i), 1'b1);
      if (i >= 3 && !m_valid_o) gaps++;
    end
    chk("t2_ready_drops", 64'(rdy_drop), 64'd0);
    chk("t2_gaps", 64'(gaps), 64'd0);
    drain("t2_drain");

    // ---- 3: fill with m_ready low ----
    acc = 0;
    for (int i = 0; i < 2000 && s_ready_o; i++) begin
      drive(1'b1, 32'h1000_0000 + DW'(i), 1'b0);
      acc++;
    end
    chk("t3_accepted", 64'(acc), 64'd1027);
    chk("t3_count", {52'd0, count_o}, 64'd1027);
    chk("t3_ready_low", {63'd0, s_ready_o}, 64'd0);
    chk("t3_rd_en_low", {63'd0, mem_rd_en_o}, 64'd0);
    chk("t3_ovf_clear", {63'd0, overflow_o}, 64'd0);
    // ---- 4: overflow while full ----
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("t4_ovf_set", {63'd0, overflow_o}, 64'd1);
    chk("t4_count", {52'd0, count_o}, 64'd1027);
    drain("t3_drain");
    chk("t4_ovf_sticky", {63'd0, overflow_o}, 64'd1);

    // ---- 5: random traffic ----
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain("t5_drain");
    chk("t5_occ_max", {63'd0, (occ_max <= 3)}, 64'd1);

    // ---- 6: reset mid-stream ----
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h6000_0000 + DW'(i), 1'b0);
    chk("t6_count_pre", {52'd0, count_o}, 64'd10);
    rst_i = 1'b1;
    m_ready_i = 1'b1;
    s_valid_i = 1'b0;
    #1;
    chk("t6_rst_m_valid", {63'd0, m_valid_o}, 64'd0);
    chk("t6_rst_count", {52'd0, count_o}, 64'd0);
    chk("t6_rst_rd_en", {63'd0, mem_rd_en_o}, 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6_ovf_cleared", {63'd0, overflow_o}, 64'd0);
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b1);
      if (m_valid_o || count_o != 0) gaps++;
    end
    chk("t6_no_stale", 64'(gaps), 64'd0);
    drive(1'b1, 32'h7777_0001, 1'b1);
    drive(1'b1, 32'h7777_0002, 1'b1);
    drain("t6_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sample_fifo_ctrl.md
Name: sample_fifo_ctrl

Overview:
Synchronous FIFO controller for the input-sample path. It drives an external simple-dual-port EBR RAM: port A is write-only and port B is read-only, configured with the registered output stage, so read latency is 2 cycles. The block accepts samples on a valid/ready slave stream and writes them to RAM. It prefetches RAM words through a 3-entry output buffer so the valid/ready master stream can sustain 1 sample per cycle.

Parameters:
DATA_WIDTH, 32, sample word width.
ADDR_DEPTH, 1024, RAM depth in words; must be a power of 2 and at least 4.
ADDR_WIDTH, clog2(ADDR_DEPTH), RAM address width.

Ports:
clk_i  in  1  single clock for the whole block and the RAM.
rst_i  in  1  reset: synchronous, active-high.
s_data_i  in  DATA_WIDTH  input sample.
s_valid_i  in  1  input sample valid.
s_ready_o  out  1  block can accept a sample.
m_data_o  out  DATA_WIDTH  output sample (head of the output buffer).
m_valid_o  out  1  output sample valid.
m_ready_i  in  1  downstream accepts the sample.
count_o  out  ADDR_WIDTH+2  total samples held (RAM + in-flight + output buffer).
empty_o  out  1  count_o == 0.
overflow_o  out  1  sticky flag: s_valid_i was high while s_ready_o was low; cleared only by reset.
mem_wr_en_o  out  1  RAM port A write enable (drives wr_en and clk_en).
mem_wr_addr_o  out  ADDR_WIDTH  RAM port A address.
mem_wr_data_o  out  DATA_WIDTH  RAM port A write data.
mem_rd_en_o  out  1  RAM port B clk_en; port B wr_en is tied 0 outside the block.
mem_rdout_clken_o  out  1  RAM port B output-register clock enable.
mem_rd_addr_o  out  ADDR_WIDTH  RAM port B address.
mem_rd_data_i  in  DATA_WIDTH  RAM port B read data.

Behaviour:
- State:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits each.
  - mem_count = wr_ptr - rd_ptr, counting words written but not yet issued for read.
  - v1 and v2 form the in-flight read pipeline.
  - The output buffer is 3 entries deep, with ob_count in 0..3.
- Reset (rst_i high at a rising edge):
  - All pointers, v1, v2, ob_count, overflow_o and the output buffer contents go to 0.
  - While rst_i is high: s_ready_o=0, m_valid_o=0, mem_wr_en_o=0, mem_rd_en_o=0, mem_rdout_clken_o=0, count_o=0, empty_o=1.
  - Reset asserted mid-stream discards all in-flight data; no output beat appears after the reset edge.
- Write side:
  - s_ready_o = !rst_i && (mem_count != ADDR_DEPTH).
  - Accept = s_valid_i && s_ready_o.
  - mem_wr_en_o = accept (combinational), mem_wr_addr_o = wr_ptr[ADDR_WIDTH-1:0], mem_wr_data_o = s_data_i.
  - wr_ptr increments on accept and wraps naturally modulo 2*ADDR_DEPTH.
- Read issue:
  - pop = m_valid_o && m_ready_i.
  - issue = !rst_i && (mem_count != 0) && (ob_count + v1 + v2 - pop < 3).
  - mem_rd_en_o = issue, mem_rd_addr_o = rd_ptr[ADDR_WIDTH-1:0]; rd_ptr increments on issue.
  - v1 <= issue, v2 <= v1. mem_rdout_clken_o = v1.
  - When v2=1, mem_rd_data_i holds the word issued two cycles earlier, and it is pushed into the output buffer at that edge.
- Collision: a word written at edge N is first issuable in the cycle after edge N, because mem_count includes it only after edge N. Same-address write/read in the same cycle cannot occur.
- Output buffer:
  - m_valid_o = (ob_count != 0); m_data_o = the oldest entry.
  - A simultaneous push and pop leaves ob_count unchanged and preserves order.
  - By construction, ob_count + v1 + v2 never exceeds 3, so a push never finds the buffer full.
- Latency: a sample accepted at edge N into an empty block gives m_valid_o=1 after edge N+3, with m_data_o equal to that sample.
- Throughput: with s_valid_i=1 and m_ready_i=1 continuously, 1 sample per cycle in steady state.
- Full: when mem_count = ADDR_DEPTH, s_ready_o=0 and no write occurs. s_ready_o returns to 1 in the cycle after an issue. Maximum count_o = ADDR_DEPTH+3.
- count_o = mem_count + v1 + v2 + ob_count, registered consistently with the state; updated every edge.
- overflow_o is set at any edge where s_valid_i=1, s_ready_o=0 and rst_i=0.

Test Plan:
1. Reset, then write a single word 0xA5A5_0001 at edge N with m_ready_i=1 -> m_valid_o rises after edge N+3 with m_data_o=0xA5A5_0001; count_o goes 1,1,1,1,0; empty_o returns to 1.
2. Stream 0..4095 with s_valid_i=1 and m_ready_i=1 continuously -> the output sequence 0..4095 is in order with no gaps after the 3-cycle fill; s_ready_o stays 1 throughout.
3. Hold m_ready_i=0 and write until s_ready_o=0 -> exactly 1027 samples accepted (ADDR_DEPTH=1024), count_o=1027, mem_rd_en_o=0 after the output buffer fills. Then set m_ready_i=1 -> all 1027 samples come out in order.
4. When full, keep s_valid_i=1 for one cycle -> overflow_o=1 and stays 1 until reset; stored data is unchanged.
5. Toggle m_ready_i pseudo-randomly (50%) with random s_valid_i for 10k cycles -> the scoreboard matches exactly, and ob_count+v1+v2 never exceeds 3.
6. Assert rst_i for 1 cycle with 10 samples in flight and m_ready_i=1 -> m_valid_o=0 from the next cycle, count_o=0, and no stale sample appears afterwards.
